// File: rtl/i2s_sample_rx.sv
// I2S slave receiver for one channel: synchronizes SCK/WS/SD to clk, deserializes
// MSB-first words and emits a sign-extended sample with a one-clk valid strobe.
module i2s_sample_rx #(
  parameter int DATA_BITS   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int CHANNEL     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i2s_sck,
  input  logic                 i2s_ws,
  input  logic                 i2s_sd,
  output logic [DATA_BITS:0]   sample,
  output logic                 sample_valid,
  output logic                 frame_err
);

  localparam int   CNT_W = $clog2(DATA_BITS + 1);
  localparam logic CH    = 1'(CHANNEL);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_prev_q;
  logic                   sck_rise;

  // One-clk registered copy of each SCK rising edge and the WS/SD values it sampled
  logic                   rise_q, ws_smp_q, sd_smp_q;
  logic                   ws_prev_q;
  logic                   ws_chg;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   word_ch_q, word_ch_d;
  logic                   restart_q, restart_d;
  logic [DATA_BITS:0]     sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  logic [DATA_BITS-1:0]   shifted;
  logic                   last_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_prev_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i2s_sck};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q    <= 1'b0;
      ws_smp_q  <= 1'b0;
      sd_smp_q  <= 1'b0;
      ws_prev_q <= 1'b0;
    end else begin
      rise_q <= sck_rise;
      if (sck_rise) begin
        ws_smp_q <= ws_sync_q[SYNC_STAGES-1];
        sd_smp_q <= sd_sync_q[SYNC_STAGES-1];
      end
      if (rise_q) ws_prev_q <= ws_smp_q;
    end
  end

  assign ws_chg   = rise_q & (ws_smp_q != ws_prev_q);
  assign shifted  = {shreg_q[DATA_BITS-2:0], sd_smp_q};
  assign last_bit = (bit_cnt_q == CNT_W'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      word_ch_q <= 1'b0;
      restart_q <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      word_ch_q <= word_ch_d;
      restart_q <= restart_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    word_ch_d = word_ch_q;
    restart_d = 1'b0;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ws_chg) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          word_ch_d = ws_smp_q;
        end
      end
      SHIFT: begin
        if (rise_q) begin
          // The bit on a WS-change edge still belongs to the old word, so it may be its LSB
          if (!ws_chg || last_bit) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              state_d = DONE;
              if (word_ch_q == CH) begin
                sample_d = {shifted[DATA_BITS-1], shifted};
                valid_d  = 1'b1;
              end
              if (ws_chg) begin
                restart_d = 1'b1;
                word_ch_d = ws_smp_q;
              end
            end
          end else begin
            ferr_d    = 1'b1;
            bit_cnt_d = '0;
            word_ch_d = ws_smp_q;
          end
        end
      end
      DONE: begin
        bit_cnt_d = '0;
        state_d   = restart_q ? SHIFT : WAIT;
        if (ws_chg) begin
          state_d   = SHIFT;
          word_ch_d = ws_smp_q;
        end
      end
      WAIT: begin
        if (ws_chg) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          word_ch_d = ws_smp_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;

endmodule

// File: doc/i2s_sample_rx.md
Name: i2s_sample_rx

Overview:
- Upstream capture stage for the equalizer datapath. Deserializes one channel of an I2S stream from the external audio ADC.
- Emits a sign-extended 25-bit sample with a one-clock `sample_valid` strobe. `sample_valid` drives the `en` input of the signal window shift register; `sample` drives its `signal` input.
- Operates as an I2S slave: SCK, WS and SD are asynchronous inputs and are synchronized to `clk`.

Parameters:
- DATA_BITS, 24: payload bits per word, MSB first.
- SYNC_STAGES, 2: synchronizer flops on each of SCK, WS and SD (minimum 2).
- CHANNEL, 0: captured channel. 0 = left (WS low), 1 = right (WS high).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- i2s_sck  input  1  I2S bit clock (asynchronous).
- i2s_ws  input  1  I2S word select (asynchronous).
- i2s_sd  input  1  I2S serial data (asynchronous).
- sample  output  25  last captured word, two's complement, bit 24 = sign extension of bit 23.
- sample_valid  output  1  one-clk strobe; `sample` is new on this cycle.
- frame_err  output  1  one-clk strobe; word cut short by a WS change.

Behaviour:
- Reset (reset = 0, asynchronous): all synchronizers, shift register, bit counter and ws_prev clear. `sample` = 0, `sample_valid` = 0, `frame_err` = 0. FSM goes to IDLE.
- Synchronization and edge detection:
  - SCK, WS and SD each pass through SYNC_STAGES flops.
  - An SCK rising edge (sck_rise) is detected as synced SCK = 1 while the previous synced SCK = 0.
  - WS and SD are sampled only on sck_rise.
  - Required input timing: SCK high and low phases each ≥ SYNC_STAGES+1 clk periods.
- WS change: on sck_rise, a sampled WS that differs from ws_prev is a WS change; ws_prev updates on every sck_rise.
  - The SD bit sampled on the WS-change edge belongs to the previous word.
  - The MSB of the new word is sampled on the next sck_rise (standard I2S one-bit delay).
- FSM states:
  - IDLE: ignore SD. On a WS change, go to SHIFT with bit_cnt = 0 and word_ch = new WS. A partial word after reset is therefore always discarded.
  - SHIFT: on each sck_rise without a WS change, shift SD into the LSB of the shift register and increment bit_cnt. When the shift makes bit_cnt reach DATA_BITS, go to DONE on that same clk.
  - DONE: held for one clk. If word_ch == CHANNEL, `sample` ← sign-extended shift register and `sample_valid` = 1 for exactly that cycle. Then go to WAIT.
  - WAIT: ignore further slot bits (slots longer than DATA_BITS, e.g. 32-bit slots). On a WS change, go to SHIFT with bit_cnt = 0 and word_ch = new WS.
- WS change while in SHIFT with bit_cnt < DATA_BITS:
  - `frame_err` pulses for one clk and the partial word is dropped (no `sample_valid`).
  - FSM restarts SHIFT with bit_cnt = 0 and word_ch = new WS.
- Latency: `sample_valid` asserts 2 clk after the clk on which the sck_rise capturing the LSB is detected (shift at +1, DONE at +2).
- Output hold: `sample` holds its value between strobes. The non-selected channel's words never alter `sample`.
- `sample_valid` and `frame_err` never assert on the same cycle. At most one `sample_valid` per WS period.
- Sign extension: sample[24] = sample[23] = word MSB. sample[23:0] = received word.

Test Plan:
- Reset, one dummy WS toggle, then left word 0x7FFFFF followed by a WS change → single `sample_valid`, `sample` = 0x07FFFFF.
- Left word 0x800000 → `sample` = 0x1800000. Next left word 0x000001 → `sample` = 0x0000001.
- Right word 0xABCDEF between two left words 0x123456 and 0x654321, CHANNEL = 0 → exactly two strobes with those values; `sample` never equals 0x1ABCDEF.
- 32-bit slots: left word 0x00F00F plus 8 trailing ones → `sample` = 0x000F00F, no `frame_err`.
- WS toggles after 10 left bits → one `frame_err` pulse, no `sample_valid`. The following full word 0x111111 is captured correctly.
- reset asserted mid-word (bit 12) then released → outputs read 0 immediately. The word in progress and the next word before the first WS change produce no strobe; the first full left word after a WS change is captured.
